// File: rtl/remme_hist.sv
// remme_hist: recall-history register for the sequence-tracking path.
//
// Every non-escape word on r is passed to m one cycle later and pushed into a
// circular history of DEPTH entries. Each consecutive all-ones escape word
// returns one history entry, walking from the newest towards the oldest.
//
// Parameters:
//   WIDTH  data width in bits (>= 2); the escape word is all ones
//   DEPTH  number of history entries (>= 1)
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   r       input word, sampled on every rising edge
//   m       registered output word
//   recall  registered; 1 when m came from an escape cycle
//   empty   registered; 1 when the history holds no entries
//
// Build option:
//   REMME_HIST_WRAP_EN  when defined, recall past the oldest valid entry wraps
//                       back to the newest; otherwise it holds on the oldest.

module remme_hist #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] m,
  output logic             recall,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [WIDTH-1:0] Esc    = '1;
  localparam logic [PtrW-1:0]  PtrMax = PtrW'(DEPTH - 1);
  localparam logic [PtrW-1:0]  PtrOne = PtrW'(1);
  localparam logic [CntW-1:0]  CntMax = CntW'(DEPTH);
  localparam logic [CntW-1:0]  CntOne = CntW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  rd_off_q, rd_off_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             recall_q, recall_d;
  logic             empty_q, empty_d;

  logic             is_esc;
  logic [PtrW-1:0]  rd_idx;
  logic             more_left;

  assign is_esc = (r == Esc);

  // (wr_ptr - 1 - rd_off) mod DEPTH with an explicit wrap, so non-power-of-two
  // depths index correctly. In the wrap branch wr_ptr <= rd_off, so the sum
  // stays within 0..DEPTH-1.
  always_comb begin
    rd_idx = '0;
    if (wr_ptr_q > rd_off_q) begin
      rd_idx = wr_ptr_q - rd_off_q - PtrOne;
    end else begin
      rd_idx = PtrMax - rd_off_q + wr_ptr_q;
    end
  end

  // Another, older valid entry exists beyond the current recall distance.
  assign more_left = ((CntW'(rd_off_q) + CntOne) < count_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rd_off_d = rd_off_q;
    m_d      = m_q;
    recall_d = 1'b0;

    if (!is_esc) begin
      wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + PtrOne;
      count_d  = (count_q == CntMax) ? count_q : count_q + CntOne;
      rd_off_d = '0;
      m_d      = r;
      recall_d = 1'b0;
    end else if (count_q != '0) begin
      m_d      = mem[rd_idx];
      recall_d = 1'b1;
      if (more_left) begin
        rd_off_d = rd_off_q + PtrOne;
      end else begin
`ifdef REMME_HIST_WRAP_EN
        rd_off_d = '0;
`else
        rd_off_d = rd_off_q;
`endif
      end
    end else begin
      m_d      = '0;
      recall_d = 1'b1;
    end

    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
      rd_off_q <= '0;
      m_q      <= '0;
      recall_q <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rd_off_q <= rd_off_d;
      m_q      <= m_d;
      recall_q <= recall_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is not reset. A write during reset can only hit entry 0 while
  // count is 0, and that entry is rewritten by the first store before any
  // escape can read it, so reset need not gate the write.
  always_ff @(posedge clk) begin
    if (!is_esc) begin
      mem[wr_ptr_q] <= r;
    end
  end

  assign m      = m_q;
  assign recall = recall_q;
  assign empty  = empty_q;

endmodule

// File: tb/tb_remme_hist.sv
module tb_remme_hist;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] m;
  logic             recall;
  logic             empty;

  remme_hist #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .r      (r),
    .m      (m),
    .recall (recall),
    .empty  (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] m;
    logic             recall;
    logic             empty;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef REMME_HIST_WRAP_EN
  localparam bit Wrap = 1'b1;
`else
  localparam bit Wrap = 1'b0;
`endif

  // Behavioural history for the random run: hist[0] is the newest entry.
  logic [WIDTH-1:0] hist[$];
  int               off;

  function automatic exp_t mk(input logic [WIDTH-1:0] mm, input logic rc, input logic em);
    exp_t e;
    e.m      = mm;
    e.recall = rc;
    e.empty  = em;
    return e;
  endfunction

  function automatic void model_reset();
    hist.delete();
    off = 0;
  endfunction

  function automatic exp_t model_step(input logic [WIDTH-1:0] w);
    exp_t e;
    if (w != '1) begin
      hist.push_front(w);
      if (hist.size() > DEPTH) void'(hist.pop_back());
      off = 0;
      e = mk(w, 1'b0, 1'b0);
    end else if (hist.size() == 0) begin
      e = mk('0, 1'b1, 1'b1);
    end else begin
      e = mk(hist[off], 1'b1, 1'b0);
      if (off + 1 < hist.size()) off = off + 1;
      else if (Wrap) off = 0;
    end
    return e;
  endfunction

  // Drive one word, then sample the registered result 1 time unit after the edge.
  task automatic cycle(input logic [WIDTH-1:0] w);
    r = w;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    reset = 1'b1;
    r     = 'x;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    exp_t e;
    reset_cycle();
    sb.push_back(mk('0, 1'b0, 1'b1));
    e = sb.pop_front();
    n_cmp++;
    if (m !== e.m || recall !== e.recall || empty !== e.empty) begin
      n_err++;
      $display("FAIL reset: got m=%h recall=%b empty=%b, want m=%h recall=%b empty=%b",
               m, recall, empty, e.m, e.recall, e.empty);
    end
  endtask

  task automatic test_walk_back();
    logic [WIDTH-1:0] seq [9] = '{4'h7, 4'h3, 4'h6, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    logic [WIDTH-1:0] em  [9] = '{4'h7, 4'h3, 4'h6, 4'h2, 4'h2, 4'h6, 4'h3, 4'h7, 4'h7};
    exp_t e;
    if (Wrap) em[8] = 4'h2;
    reset_cycle();
    for (int i = 0; i < 9; i++) begin
      sb.push_back(mk(em[i], (i >= 4), 1'b0));
      cycle(seq[i]);
      e = sb.pop_front();
      n_cmp++;
      if (m !== e.m || recall !== e.recall || empty !== e.empty) begin
        n_err++;
        $display("FAIL walk_back[%0d]: got m=%h recall=%b empty=%b, want m=%h recall=%b empty=%b",
                 i, m, recall, empty, e.m, e.recall, e.empty);
      end
    end
  endtask

  task automatic test_overwrite();
    logic [WIDTH-1:0] seq [9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF, 4'hF, 4'hF, 4'hF};
    logic [WIDTH-1:0] em  [9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h5, 4'h4, 4'h3, 4'h2};
    exp_t e;
    reset_cycle();
    for (int i = 0; i < 9; i++) begin
      sb.push_back(mk(em[i], (i >= 5), 1'b0));
      cycle(seq[i]);
      e = sb.pop_front();
      n_cmp++;
      if (m !== e.m || recall !== e.recall || empty !== e.empty) begin
        n_err++;
        $display("FAIL overwrite[%0d]: got m=%h recall=%b empty=%b, want m=%h recall=%b empty=%b",
                 i, m, recall, empty, e.m, e.recall, e.empty);
      end
    end
  endtask

  task automatic test_partial_restore();
    logic [WIDTH-1:0] seq [7] = '{4'h9, 4'hA, 4'hF, 4'hF, 4'hF, 4'h5, 4'hF};
    logic [WIDTH-1:0] em  [7] = '{4'h9, 4'hA, 4'hA, 4'h9, 4'h9, 4'h5, 4'h5};
    logic             er  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_t e;
    if (Wrap) em[4] = 4'hA;
    reset_cycle();
    for (int i = 0; i < 7; i++) begin
      sb.push_back(mk(em[i], er[i], 1'b0));
      cycle(seq[i]);
      e = sb.pop_front();
      n_cmp++;
      if (m !== e.m || recall !== e.recall || empty !== e.empty) begin
        n_err++;
        $display("FAIL partial[%0d]: got m=%h recall=%b empty=%b, want m=%h recall=%b empty=%b",
                 i, m, recall, empty, e.m, e.recall, e.empty);
      end
    end
  endtask

  task automatic test_empty_escape();
    logic [WIDTH-1:0] seq [3] = '{4'hF, 4'hF, 4'h3};
    exp_t e;
    reset_cycle();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) sb.push_back(mk(4'h0, 1'b1, 1'b1));
      else       sb.push_back(mk(4'h3, 1'b0, 1'b0));
      cycle(seq[i]);
      e = sb.pop_front();
      n_cmp++;
      if (m !== e.m || recall !== e.recall || empty !== e.empty) begin
        n_err++;
        $display("FAIL empty_esc[%0d]: got m=%h recall=%b empty=%b, want m=%h recall=%b empty=%b",
                 i, m, recall, empty, e.m, e.recall, e.empty);
      end
    end
  endtask

  task automatic test_reset_mid_recall();
    logic [WIDTH-1:0] seq [3] = '{4'h4, 4'h8, 4'hF};
    logic [WIDTH-1:0] em  [3] = '{4'h4, 4'h8, 4'h8};
    exp_t e;
    reset_cycle();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(em[i], (i == 2), 1'b0));
      cycle(seq[i]);
      e = sb.pop_front();
      n_cmp++;
      if (m !== e.m || recall !== e.recall || empty !== e.empty) begin
        n_err++;
        $display("FAIL mid_recall[%0d]: got m=%h recall=%b empty=%b, want m=%h recall=%b empty=%b",
                 i, m, recall, empty, e.m, e.recall, e.empty);
      end
    end
    // Assert reset between edges; outputs must clear before the next edge.
    #2;
    reset = 1'b1;
    r     = 'x;
    #1;
    sb.push_back(mk('0, 1'b0, 1'b1));
    e = sb.pop_front();
    n_cmp++;
    if (m !== e.m || recall !== e.recall || empty !== e.empty) begin
      n_err++;
      $display("FAIL async_reset: got m=%h recall=%b empty=%b, want m=%h recall=%b empty=%b",
               m, recall, empty, e.m, e.recall, e.empty);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    sb.push_back(mk('0, 1'b1, 1'b1));
    cycle(4'hF);
    e = sb.pop_front();
    n_cmp++;
    if (m !== e.m || recall !== e.recall || empty !== e.empty) begin
      n_err++;
      $display("FAIL after_reset_esc: got m=%h recall=%b empty=%b, want m=%h recall=%b empty=%b",
               m, recall, empty, e.m, e.recall, e.empty);
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] w;
    exp_t             e;
    bit               stop = 1'b0;
    reset_cycle();
    for (int i = 0; i < 300 && !stop; i++) begin
      if (i == 150) begin
        #2;
        reset = 1'b1;
        r     = 'x;
        model_reset();
        #1;
        sb.push_back(mk('0, 1'b0, 1'b1));
        e = sb.pop_front();
        n_cmp++;
        if (m !== e.m || recall !== e.recall || empty !== e.empty) begin
          n_err++;
          stop = 1'b1;
          $display("FAIL random_reset: got m=%h recall=%b empty=%b, want m=%h recall=%b empty=%b",
                   m, recall, empty, e.m, e.recall, e.empty);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
      if (!stop) begin
        w = ($urandom_range(0, 99) < 30) ? 4'hF : WIDTH'($urandom);
        sb.push_back(model_step(w));
        cycle(w);
        e = sb.pop_front();
        n_cmp++;
        if (m !== e.m || recall !== e.recall || empty !== e.empty) begin
          n_err++;
          stop = 1'b1;
          $display("FAIL random[%0d] r=%h: got m=%h recall=%b empty=%b, want m=%h recall=%b empty=%b",
                   i, w, m, recall, empty, e.m, e.recall, e.empty);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    r     = '0;
    model_reset();
    #1;
    test_reset();
    test_walk_back();
    test_overwrite();
    test_partial_restore();
    test_empty_escape();
    test_reset_mid_recall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/remme_hist.md
# remme_hist

Parametrised recall-history register for the sequence-tracking path. Every non-escape input word is passed through to `m` one cycle later and pushed into a circular history of `DEPTH` entries. The all-ones escape word walks backwards through that history, newest first, one entry per consecutive escape cycle. This generalises the fixed 4-bit, single-entry remember-me behaviour to arbitrary width and history depth, and adds an optional wrap-around recall mode.

## Interface
- `WIDTH`, default 4: data width in bits; must be ≥2. Escape word `ESC` = all ones (`{WIDTH{1'b1}}`).
- `DEPTH`, default 4: number of history entries; must be ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `r`  in  WIDTH  input word, sampled on every rising edge.
- `m`  out  WIDTH  registered output word.
- `recall`  out  1  registered; 1 when `m` was produced by an escape cycle.
- `empty`  out  1  registered; 1 when the history holds no entries.

## Operation
- Internal state:
  - `mem[DEPTH]`: storage, not reset.
  - `wr_ptr`: range 0..DEPTH-1.
  - `count`: range 0..DEPTH, saturating.
  - `rd_off`: range 0..DEPTH-1, recall distance from the newest entry.
- States, derived from the registers:
  - EMPTY: `count==0`.
  - STORE: `count>0`, last cycle was not an escape.
  - RECALL: `count>0`, last cycle was an escape.
- Store cycle, `r != ESC`:
  - `mem[wr_ptr] <= r`.
  - `wr_ptr <= (wr_ptr+1) mod DEPTH`.
  - `count <= min(count+1, DEPTH)`. When full, the oldest entry is overwritten.
  - `m <= r`, `recall <= 0`, `rd_off <= 0`. Next state is STORE.
- Escape cycle, `r == ESC`, with `count>0`:
  - `m <= mem[(wr_ptr-1-rd_off) mod DEPTH]`, `recall <= 1`. Next state is RECALL.
  - `rd_off` advances to `rd_off+1` if `rd_off+1 < count`. Otherwise it is handled per the Configuration section.
  - The history is not modified.
- Escape cycle, `r == ESC`, with `count==0`: `m <= 0`, `recall <= 1`. State stays EMPTY.
- `empty <= (next count == 0)`.
- Pointer arithmetic is modulo `DEPTH` and must be correct for non-power-of-two `DEPTH`. Use explicit compare-and-wrap, not bit truncation.
- The first escape after any store always returns the word just stored.

## Timing
- Latency is 1 cycle: `m`, `recall` and `empty` reflect the `r` sampled at the previous rising edge.
- Reset values: `m=0`, `recall=0`, `empty=1`, `count=0`, `wr_ptr=0`, `rd_off=0`.
- Reset asserted mid-recall or mid-store:
  - All outputs and state go to their reset values immediately, without waiting for a clock edge.
  - The history is logically discarded, so `count=0`.
- `r` is ignored while `reset` is high. X on `r` during reset must not propagate.
- First edge after reset deasserts: `r` is processed normally.
- There is no handshake. Exactly one word is consumed per cycle.

## Configuration
- `REMME_HIST_WRAP_EN`, defined: when a recall reaches the oldest valid entry (`rd_off+1 == count`), `rd_off <= 0`. The next escape returns the newest entry again, cycling indefinitely.
- Undefined (default): recall saturates. `rd_off` holds at `count-1`, and further escapes keep returning the oldest valid entry.
- The macro affects only this rule. All other behaviour is identical in both builds.

## Test plan
All scenarios use `WIDTH=4`, `DEPTH=4`, and each starts with one reset cycle.
- Walk-back: `r` = 7,3,6,2,F,F,F,F,F.
  - `m` = 7,3,6,2,2,6,3,7, then the last escape gives 7 (default build) or 2 (`REMME_HIST_WRAP_EN`).
  - `recall` = 1 on the escape outputs only.
- Overwrite: `r` = 1,2,3,4,5,F,F,F,F.
  - Escape outputs are 5,4,3,2, and 1 is never returned.
  - `empty` = 0 from the first store onward.
- Partial history and re-store: `r` = 9,A,F,F,F,5,F.
  - Escape outputs are A,9, then 9 (saturate) or A (wrap).
  - Then `m` = 5, then 5, showing `rd_off` restarts at the newest entry.
- Empty escape: after reset, `r` = F,F.
  - `m` = 0,0, `recall` = 1,1, `empty` = 1,1.
  - Then `r` = 3 gives `m` = 3 and `empty` = 0.
- Reset mid-recall: `r` = 4,8,F, then assert `reset` asynchronously between edges.
  - Outputs go to `m=0`, `recall=0`, `empty=1` before the next edge.
  - After release, `r` = F gives `m` = 0.
- Random regression: 300 cycles of `$random` words, about 30% forced to F, with a mid-run reset. Compare every cycle against a behavioural model and stop on the first mismatch.
